scoreboard_regfile: RTL and testbench

//  Parametrised architectural register file with per-register busy/tag scoreboard for the OoO core.

---
 rtl/scoreboard_regfile.sv | 136 +++++++++++++
 tb/tb_scoreboard_regfile.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_regfile.sv
// scoreboard_regfile
//   Architectural register file with a per-register busy/tag scoreboard.
//   It sits between decode/dispatch and the ROB commit path. It supplies
//   operands plus ready/tag to the reservation stations, accepts several
//   in-order commits per cycle, bypasses commit data to the reads, and
//   supports a flush for mispredict recovery.
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   flush       clear all busy bits and tags; same-cycle dispatch is ignored
//   disp_*      dispatch of an instruction that writes disp_rd with ROB tag disp_tag
//   wb_*        NWR commit ports; a higher port index is a younger instruction
//   rs_idx      NRD read addresses
//   rs_data     read data (combinational)
//   rs_ready    1 = rs_data is valid; 0 = wait for the ROB tag on rs_tag
//   rs_tag      ROB tag of the producer when not ready, otherwise 0
module scoreboard_regfile #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 disp_valid,
  input  logic [AW-1:0]        disp_rd,
  input  logic [TAG_W-1:0]     disp_tag,
  input  logic [NWR-1:0]       wb_valid,
  input  logic [NWR*AW-1:0]    wb_rd,
  input  logic [NWR*TAG_W-1:0] wb_tag,
  input  logic [NWR*WIDTH-1:0] wb_data,
  input  logic [NRD*AW-1:0]    rs_idx,
  output logic [NRD*WIDTH-1:0] rs_data,
  output logic [NRD-1:0]       rs_ready,
  output logic [NRD*TAG_W-1:0] rs_tag
);

  logic [WIDTH-1:0] r_data [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [TAG_W-1:0] r_tag  [NREGS];

  logic [AW-1:0]    w_wb_rd   [NWR];
  logic [TAG_W-1:0] w_wb_tag  [NWR];
  logic [WIDTH-1:0] w_wb_data [NWR];
  logic [NREGS-1:0] w_clr;
  logic             w_disp;

  always_comb begin
    for (int unsigned i = 0; i < NWR; i++) begin
      w_wb_rd[i]   = wb_rd[i*AW +: AW];
      w_wb_tag[i]  = wb_tag[i*TAG_W +: TAG_W];
      w_wb_data[i] = wb_data[i*WIDTH +: WIDTH];
    end
  end

  assign w_disp = disp_valid && (disp_rd != '0) && !flush;

  // Busy clear is decided by the youngest (highest-index) commit port that
  // targets the register: later loop iterations overwrite earlier ones.
  always_comb begin
    w_clr = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      for (int unsigned i = 0; i < NWR; i++) begin
        if (wb_valid[i] && (w_wb_rd[i] == AW'(r)))
          w_clr[r] = (w_wb_tag[i] == r_tag[r]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      for (int unsigned r = 0; r < NREGS; r++) begin
        r_data[r] <= '0;
        r_tag[r]  <= '0;
      end
    end else begin
      // Ascending port order lets the youngest commit win the data write.
      for (int unsigned i = 0; i < NWR; i++) begin
        if (wb_valid[i] && (w_wb_rd[i] != '0))
          r_data[w_wb_rd[i]] <= w_wb_data[i];
      end
      for (int unsigned r = 1; r < NREGS; r++) begin
        if (flush) begin
          r_busy[r] <= 1'b0;
          r_tag[r]  <= '0;
        end else if (w_disp && (disp_rd == AW'(r))) begin
          r_busy[r] <= 1'b1;
          r_tag[r]  <= disp_tag;
        end else if (w_clr[r]) begin
          r_busy[r] <= 1'b0;
          r_tag[r]  <= '0;
        end
      end
    end
  end

  // Combinational read with commit bypass. The bypass picks the highest
  // commit port whose tag matches the stored tag, independent of which port
  // decides the busy clear.
  always_comb begin
    rs_data  = '0;
    rs_ready = '0;
    rs_tag   = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      logic [AW-1:0]    idx;
      logic             hit;
      logic [WIDTH-1:0] bdata;
      idx   = rs_idx[p*AW +: AW];
      hit   = 1'b0;
      bdata = '0;
      for (int unsigned i = 0; i < NWR; i++) begin
        if (wb_valid[i] && (w_wb_rd[i] == idx) && (w_wb_tag[i] == r_tag[idx])) begin
          hit   = 1'b1;
          bdata = w_wb_data[i];
        end
      end
      if (idx == '0) begin
        rs_ready[p] = 1'b1;
      end else if (r_busy[idx] && hit) begin
        rs_data[p*WIDTH +: WIDTH] = bdata;
        rs_ready[p]               = 1'b1;
      end else if (r_busy[idx]) begin
        rs_data[p*WIDTH +: WIDTH] = r_data[idx];
        rs_tag[p*TAG_W +: TAG_W]  = r_tag[idx];
      end else begin
        rs_data[p*WIDTH +: WIDTH] = r_data[idx];
        rs_ready[p]               = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
module tb_scoreboard_regfile;

  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int TAG_W = 4;
  localparam int AW    = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 disp_valid;
  logic [AW-1:0]        disp_rd;
  logic [TAG_W-1:0]     disp_tag;
  logic [NWR-1:0]       wb_valid;
  logic [NWR*AW-1:0]    wb_rd;
  logic [NWR*TAG_W-1:0] wb_tag;
  logic [NWR*WIDTH-1:0] wb_data;
  logic [NRD*AW-1:0]    rs_idx;
  logic [NRD*WIDTH-1:0] rs_data;
  logic [NRD-1:0]       rs_ready;
  logic [NRD*TAG_W-1:0] rs_tag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string            name;
    int               port;
    logic [WIDTH-1:0] data;
    logic             ready;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  scoreboard_regfile #(
    .WIDTH(WIDTH), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_tag(disp_tag),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_tag(wb_tag), .wb_data(wb_data),
    .rs_idx(rs_idx), .rs_data(rs_data), .rs_ready(rs_ready), .rs_tag(rs_tag)
  );

  task automatic idle();
    flush      = 1'b0;
    disp_valid = 1'b0;
    disp_rd    = '0;
    disp_tag   = '0;
    wb_valid   = '0;
    wb_rd      = '0;
    wb_tag     = '0;
    wb_data    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic disp(input int rd, input int tag);
    disp_valid = 1'b1;
    disp_rd    = AW'(rd);
    disp_tag   = TAG_W'(tag);
  endtask

  task automatic wb(input int p, input int rd, input int tag, input logic [WIDTH-1:0] d);
    wb_valid[p]                = 1'b1;
    wb_rd[p*AW +: AW]          = AW'(rd);
    wb_tag[p*TAG_W +: TAG_W]   = TAG_W'(tag);
    wb_data[p*WIDTH +: WIDTH]  = d;
  endtask

  // Drive a read address and push the expected result to the scoreboard.
  task automatic rd(input string name, input int p, input int idx,
                    input logic [WIDTH-1:0] d, input logic rdy, input int tag);
    exp_t e;
    rs_idx[p*AW +: AW] = AW'(idx);
    e.name  = name;
    e.port  = p;
    e.data  = d;
    e.ready = rdy;
    e.tag   = TAG_W'(tag);
    q.push_back(e);
  endtask

  // Let the combinational reads settle, then pop and compare every entry.
  task automatic chk();
    exp_t             e;
    logic [WIDTH-1:0] od;
    logic             orr;
    logic [TAG_W-1:0] ot;
    #1;
    while (q.size() > 0) begin
      e   = q.pop_front();
      od  = rs_data[e.port*WIDTH +: WIDTH];
      orr = rs_ready[e.port];
      ot  = rs_tag[e.port*TAG_W +: TAG_W];
      checks++;
      assert (od === e.data) else begin
        errors++;
        $error("FAIL %s port%0d data observed=%h expected=%h", e.name, e.port, od, e.data);
      end
      checks++;
      assert (orr === e.ready) else begin
        errors++;
        $error("FAIL %s port%0d ready observed=%b expected=%b", e.name, e.port, orr, e.ready);
      end
      checks++;
      assert (ot === e.tag) else begin
        errors++;
        $error("FAIL %s port%0d tag observed=%h expected=%h", e.name, e.port, ot, e.tag);
      end
    end
  endtask

  initial begin
    rst    = 1'b0;
    rs_idx = '0;
    idle();
    #12;
    rst = 1'b1;
    tick();

    // Populate some state, then reset mid-operation with a dispatch in flight.
    wb(0, 6, 0, 32'h55);
    disp(5, 3);
    tick();
    disp(6, 2);
    wb(1, 6, 0, 32'h66);
    #2;
    rst = 1'b0;
    rd("reset_async", 0, 6, 32'h0, 1'b1, 0);
    chk();
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    tick();
    for (int i = 1; i < NREGS; i++) begin
      rd("reset", 0, i, 32'h0, 1'b1, 0);
      rd("reset", 1, i, 32'h0, 1'b1, 0);
      chk();
    end

    // Dispatch then commit with bypass.
    disp(5, 3);
    tick();
    rd("disp_busy", 0, 5, 32'h0, 1'b0, 3);
    chk();
    wb(0, 5, 3, 32'hDEADBEEF);
    rd("bypass", 0, 5, 32'hDEADBEEF, 1'b1, 0);
    rd("bypass", 1, 5, 32'hDEADBEEF, 1'b1, 0);
    chk();
    tick();
    rd("commit_clear", 0, 5, 32'hDEADBEEF, 1'b1, 0);
    chk();

    // Stale commit from an older writer leaves the younger tag outstanding.
    disp(7, 1);
    tick();
    disp(7, 2);
    tick();
    rd("rename", 0, 7, 32'h0, 1'b0, 2);
    chk();
    wb(0, 7, 1, 32'h11);
    rd("stale_no_bypass", 0, 7, 32'h0, 1'b0, 2);
    chk();
    tick();
    rd("stale_commit", 0, 7, 32'h11, 1'b0, 2);
    chk();

    // Commit and dispatch to the same register in the same cycle.
    disp(9, 4);
    tick();
    wb(0, 9, 4, 32'h22);
    disp(9, 6);
    rd("disp_invisible", 0, 9, 32'h22, 1'b1, 0);
    chk();
    tick();
    rd("disp_over_clear", 0, 9, 32'h22, 1'b0, 6);
    chk();

    // Two commit ports on the same register: port1 holds the matching tag.
    disp(3, 7);
    tick();
    wb(0, 3, 2, 32'hA);
    wb(1, 3, 7, 32'hB);
    rd("dual_bypass", 0, 3, 32'hB, 1'b1, 0);
    chk();
    tick();
    rd("dual_commit", 1, 3, 32'hB, 1'b1, 0);
    chk();

    // Two commit ports on the same register: only port0 holds the matching tag.
    disp(12, 5);
    tick();
    wb(0, 12, 5, 32'hC);
    wb(1, 12, 6, 32'hD);
    rd("dual_bypass_p0", 0, 12, 32'hC, 1'b1, 0);
    chk();
    tick();
    rd("dual_p1_wins", 0, 12, 32'hD, 1'b0, 5);
    chk();

    // Register 0 ignores dispatch and commit.
    disp(0, 9);
    wb(0, 0, 0, 32'hFF);
    rd("x0_same", 0, 0, 32'h0, 1'b1, 0);
    rd("x0_same", 1, 0, 32'h0, 1'b1, 0);
    chk();
    tick();
    rd("x0_next", 0, 0, 32'h0, 1'b1, 0);
    chk();

    // Flush with outstanding writers and a same-cycle dispatch.
    disp(4, 1);
    tick();
    disp(8, 2);
    tick();
    rd("pre_flush", 0, 4, 32'h0, 1'b0, 1);
    rd("pre_flush", 1, 8, 32'h0, 1'b0, 2);
    chk();
    flush = 1'b1;
    disp(10, 3);
    wb(0, 11, 0, 32'h77);
    tick();
    rd("flush", 0, 4, 32'h0, 1'b1, 0);
    rd("flush", 1, 8, 32'h0, 1'b1, 0);
    chk();
    rd("flush_disp", 0, 10, 32'h0, 1'b1, 0);
    rd("flush_commit", 1, 11, 32'h77, 1'b1, 0);
    chk();
    rd("flush_older", 0, 12, 32'hD, 1'b1, 0);
    chk();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
